// File: rtl/uart_pkg.sv
// Purpose: shared types and frame-format constants for the tick-driven UART transmitter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  // Legal frame-format ranges.
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Parity over up to 9 data bits. Callers zero-extend narrower data, which
  // leaves the XOR unchanged. Even parity = XOR, odd parity = XNOR.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_tick_edge_tick.sv
// Purpose: one-register rising-edge detector turning a divided clock into single-cycle ticks.
// Latency: tick is combinational from din; prev lags din by one cycle.
// Backpressure: none; a tick is produced on every rising edge of din.
//
// Ports:
//   clk  - system clock (din must already be synchronous to it)
//   rst  - synchronous active-low reset; prev loads PREV_RST
//   din  - divided clock / level to edge-detect
//   tick - high for one cycle when din is high and was low the previous cycle
module edge_tick #(
  // Reset value of the history register. Setting it to 1 stops a level that
  // is already high at reset release from being reported as a rising edge.
  parameter logic PREV_RST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tick
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= PREV_RST;
    end else begin
      prev <= din;
    end
  end

  assign tick = din & ~prev;

endmodule

// File: rtl/uart_tx_tick.sv
// Purpose: UART transmitter (start, DATA_BITS LSB-first, optional parity, 1..2 stop) paced by baud_clk rising edges.
// Latency: start bit begins 1..one tick period after accept; every bit lasts exactly one tick period.
// Backpressure: tx_ready is high only in IDLE; a byte is taken when tx_valid & tx_ready at a clock edge.
//
// Ports:
//   clk_ref    - system clock, same clock as the baud divider
//   rst        - synchronous active-low reset
//   baud_clk   - divided clock, registered in the clk_ref domain
//   tx_data    - byte to send, sampled on accept
//   tx_valid   - tx_data is valid
//   parity_en  - append a parity bit to this frame
//   parity_odd - 1 = odd parity, 0 = even parity
//   tx_ready   - block can accept a byte (IDLE)
//   tx         - serial line, idle high, registered
//   busy       - frame in progress (~tx_ready)
//   tx_done    - one-cycle pulse on the final stop-bit tick
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_ref,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  // In DATA the counter holds the number of data bits already put on the
  // line, so reaching DATA_BITS means the last data bit has just finished.
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS);
  // In STOP the counter holds the number of stop ticks already seen.
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_tick: DATA_BITS out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_tick: STOP_BITS out of range");
  end

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic                 par_en_q;
  logic                 par_q;
  logic [CW-1:0]        cnt;
  logic                 tick;

  // baud_clk is already registered in this domain, so no synchronizer.
  edge_tick #(
    .PREV_RST (1'b1)
  ) u_edge_tick (
    .clk  (clk_ref),
    .rst  (rst),
    .din  (baud_clk),
    .tick (tick)
  );

  // Derived from registered state only; tx_valid never reaches these.
  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;

  // Asserted during the tick cycle that ends the last stop bit, so tx_ready
  // rises the cycle after. Gated by rst so an abandoned frame never reports done.
  assign tx_done = rst & tick & (state == STOP) & (cnt == STOP_LAST);

  always_ff @(posedge clk_ref) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Ticks are ignored here; ALIGN waits for a fresh one so the line
          // always idles high for at least part of a bit before the start bit.
          if (tx_valid) begin
            shift    <= tx_data;
            par_en_q <= parity_en;
            par_q    <= calc_parity(9'(tx_data), parity_odd);
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          if (tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shift[0];
            shift <= shift >> 1;
            cnt   <= CW'(1);
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (cnt == DATA_LAST) begin
              cnt <= '0;
              if (par_en_q) begin
                tx    <= par_q;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx    <= shift[0];
              shift <= shift >> 1;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (cnt == STOP_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Purpose: scoreboard bench for uart_tx_tick (8N1-style and 7-bit/2-stop instances).
// Latency: baud_clk toggles every 2 clk_ref cycles, so one bit = 4 cycles.
// Backpressure: stimulus waits on tx_ready before each accept.
module tb_uart_tx_tick;

  logic       clk_ref    = 1'b0;
  logic       rst        = 1'b0;
  logic       baud_clk   = 1'b1;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_valid   = 1'b0;
  logic       parity_en  = 1'b0;
  logic       parity_odd = 1'b0;
  logic       sel        = 1'b0;   // 0: 8-bit/1-stop DUT, 1: 7-bit/2-stop DUT
  logic       baud_run   = 1'b0;

  logic rdy8, tx8, busy8, done8;
  logic rdy7, tx7, busy7, done7;
  logic v8, v7;
  logic m_tx, m_rdy, m_done;

  assign v8     = tx_valid & ~sel;
  assign v7     = tx_valid & sel;
  assign m_tx   = sel ? tx7   : tx8;
  assign m_rdy  = sel ? rdy7  : rdy8;
  assign m_done = sel ? done7 : done8;

  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1)) dut8 (
    .clk_ref (clk_ref), .rst (rst), .baud_clk (baud_clk),
    .tx_data (tx_data), .tx_valid (v8),
    .parity_en (parity_en), .parity_odd (parity_odd),
    .tx_ready (rdy8), .tx (tx8), .busy (busy8), .tx_done (done8)
  );

  uart_tx_tick #(.DATA_BITS(7), .STOP_BITS(2)) dut7 (
    .clk_ref (clk_ref), .rst (rst), .baud_clk (baud_clk),
    .tx_data (tx_data[6:0]), .tx_valid (v7),
    .parity_en (parity_en), .parity_odd (parity_odd),
    .tx_ready (rdy7), .tx (tx7), .busy (busy7), .tx_done (done7)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    logic [15:0] pat;    // line sequence, first bit at position nbits-1
    int          nbits;
    bit          gap;    // require >= one bit period of idle before start
    bit          abort;  // frame is expected to be killed by reset
  } exp_t;

  exp_t exp_q[$];
  int   tests       = 0;
  int   fails       = 0;
  int   frames_done = 0;
  int   stray_done  = 0;
  bit   mon_busy    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_frame(input logic [15:0] pat, input int nbits, input bit gap, input bit abort);
    exp_t e;
    e.pat = pat; e.nbits = nbits; e.gap = gap; e.abort = abort;
    exp_q.push_back(e);
  endtask

  // Divided clock: toggles every 2 cycles while running, parked high otherwise.
  initial begin : baud_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_ref); #1;
      if (!baud_run) begin
        baud_clk = 1'b1; cnt = 0;
      end else if (cnt == 1) begin
        baud_clk = ~baud_clk; cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Monitor: decodes frames from the selected line and compares them with the queue.
  initial begin : monitor
    exp_t        e;
    logic        prev_tx;
    int          idle_run;
    logic        bitv;
    logic [15:0] got;
    bit          hold_ok, done_ok, aborted, last;
    prev_tx  = 1'b1;
    idle_run = 0;
    bitv     = 1'b1;
    forever begin
      @(negedge clk_ref);
      if (!rst) begin
        idle_run = 0;
      end else if (prev_tx && !m_tx) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e        = exp_q.pop_front();
          mon_busy = 1'b1;
          if (e.gap) check("idle_gap_ge_bit", 32'(idle_run >= 4), 32'd1);
          got = '0; hold_ok = 1'b1; done_ok = 1'b1; aborted = 1'b0;
          for (int b = 0; b < e.nbits && !aborted; b++) begin
            for (int s = 0; s < 4 && !aborted; s++) begin
              if (b != 0 || s != 0) @(negedge clk_ref);
              if (!rst) begin
                aborted = 1'b1;
              end else begin
                if (s == 0) bitv = m_tx;
                else if (m_tx !== bitv) hold_ok = 1'b0;
                last = (b == e.nbits - 1) && (s == 3);
                if (m_done !== last) done_ok = 1'b0;
              end
            end
            if (!aborted) got = {got[14:0], bitv};
          end
          check("frame_abort", 32'(aborted), 32'(e.abort));
          if (!aborted) begin
            check("frame_bits", 32'(got), 32'(e.pat));
            check("bit_hold_4cyc", 32'(hold_ok), 32'd1);
            check("tx_done_position", 32'(done_ok), 32'd1);
            frames_done++;
          end
          idle_run = 0;
          mon_busy = 1'b0;
        end
      end else begin
        if (m_done) stray_done++;
        idle_run = m_tx ? idle_run + 1 : 0;
      end
      prev_tx = m_tx;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    do begin @(negedge clk_ref); n++; end while (!m_rdy && n < 500);
    if (n >= 500) check("accept_timeout", 32'd1, 32'd0);
  endtask

  // Present a byte, hold until accepted, then scramble the inputs.
  task automatic send(input logic [7:0] d, input logic pe, input logic po);
    @(posedge clk_ref); #1;
    tx_data = d; parity_en = pe; parity_odd = po; tx_valid = 1'b1;
    wait_ready();
    @(posedge clk_ref); #1;
    tx_valid = 1'b0; tx_data = ~d; parity_en = ~pe; parity_odd = ~po;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk_ref); n++; end
      while ((exp_q.size() != 0 || mon_busy || !m_rdy) && n < 3000);
    if (n >= 3000) check("frame_timeout", 32'd1, 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int n;
    // Reset with baud_clk parked high.
    repeat (4) @(posedge clk_ref);
    #1 rst = 1'b1;
    @(negedge clk_ref);
    check("reset_state8", {28'd0, tx8, rdy8, busy8, done8}, 32'b1100);
    check("reset_state7", {28'd0, tx7, rdy7, busy7, done7}, 32'b1100);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk_ref);
      if (!(tx8 && rdy8 && !done8 && tx7 && rdy7 && !done7)) ok = 1'b0;
    end
    check("reset_release_idle_20cyc", 32'(ok), 32'd1);

    // Accept while baud_clk is stuck: stalls in ALIGN, then completes once it runs.
    expect_frame(16'b0101001011, 10, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk_ref);
      if (!(tx8 && busy8 && !rdy8)) ok = 1'b0;
    end
    check("stuck_baud_stall", 32'(ok), 32'd1);
    @(posedge clk_ref); #1 baud_run = 1'b1;
    wait_done();

    // Parity variants.
    expect_frame(16'b01010010101, 11, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    wait_done();
    expect_frame(16'b01010010111, 11, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b1);
    wait_done();
    expect_frame(16'b01000000011, 11, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    wait_done();

    // Back-to-back with tx_valid held high and data changed mid-frame.
    expect_frame(16'b0101010101, 10, 1'b0, 1'b0);
    expect_frame(16'b0010101011, 10, 1'b1, 1'b0);
    @(posedge clk_ref); #1;
    tx_data = 8'h55; parity_en = 1'b0; parity_odd = 1'b0; tx_valid = 1'b1;
    wait_ready();
    @(posedge clk_ref); #1;
    tx_data = 8'h0F; parity_en = 1'b1;
    repeat (10) @(posedge clk_ref);
    #1 tx_data = 8'hAA; parity_en = 1'b0;
    wait_ready();
    @(posedge clk_ref); #1 tx_valid = 1'b0;
    wait_done();

    // 7 data bits, 2 stop bits.
    @(posedge clk_ref); #1 sel = 1'b1;
    expect_frame(16'b0111111111, 10, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    wait_done();
    expect_frame(16'b01010110111, 11, 1'b0, 1'b0);
    send(8'h35, 1'b1, 1'b1);
    wait_done();
    @(posedge clk_ref); #1 sel = 1'b0;

    // Reset during data bit 3 of an all-zero byte.
    expect_frame(16'b0, 10, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    n = 0;
    while (tx8 && n < 200) begin @(negedge clk_ref); n++; end
    if (n >= 200) check("start_timeout", 32'd1, 32'd0);
    repeat (17) @(negedge clk_ref);
    @(posedge clk_ref); #1 rst = 1'b0;
    @(posedge clk_ref); #1;
    check("reset_midframe_idle", {28'd0, tx8, rdy8, busy8, done8}, 32'b1100);
    rst = 1'b1;
    repeat (20) @(negedge clk_ref);
    expect_frame(16'b0101001011, 10, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    wait_done();

    repeat (10) @(negedge clk_ref);
    check("stray_tx_done", 32'(stray_done), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("frames_completed", 32'(frames_done), 32'd9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
